// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver plus make/break decoder producing a held-key vector {Up, Down, Left, Right}; define PS2_WASD_EN to also map W/S/A/D.
// Latency: the filtered clock falls 2 + FILTER_LEN clk after the pin does; code_valid/frame_err follow one clk after the stop-bit strobe, and buttons one clk after that.
// Backpressure: none. The keyboard sets the pace, and every output pulse lasts exactly one cycle.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] r_bar_buttons,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_e;

    logic [1:0]     clk_sync_q, clk_sync_d;
    logic [1:0]     dat_sync_q, dat_sync_d;
    logic           filt_q, filt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           fall_stb;
    logic           rx_bit;

    rx_state_e      state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [TCW-1:0] tmo_q, tmo_d;
    logic [7:0]     code_q, code_d;
    logic           code_valid_q, code_valid_d;
    logic           frame_err_q, frame_err_d;

    logic           ext_q, ext_d;
    logic           brk_q, brk_d;
    logic [3:0]     btn_q, btn_d;

    // Synchroniser stages and the glitch filter idle high, matching the released PS/2 line.
    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_data};
        filt_d     = filt_q;
        fcnt_d     = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                fcnt_d = fcnt_q + FCW'(1);
            end
        end
    end

    assign fall_stb = filt_q & ~filt_d;
    assign rx_bit   = dat_sync_q[1];

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        tmo_d        = tmo_q;
        code_d       = code_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (fall_stb) begin
            tmo_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (!rx_bit) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    shift_d   = {rx_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_d   = rx_bit;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (rx_bit && (^{shift_q, par_q})) begin
                        code_d       = shift_q;
                        code_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            // A strobe in the same cycle takes the branch above, so it always beats the timeout.
            if (tmo_q == TCW'(TIMEOUT_CYCLES - 1)) begin
                state_d     = S_IDLE;
                tmo_d       = '0;
                frame_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TCW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        btn_d = btn_q;
        if (frame_err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (code_valid_q) begin
            if (code_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (code_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                if (ext_q) begin
                    case (code_q)
                        8'h75:   btn_d[3] = ~brk_q;
                        8'h72:   btn_d[2] = ~brk_q;
                        8'h6B:   btn_d[1] = ~brk_q;
                        8'h74:   btn_d[0] = ~brk_q;
                        default: ;
                    endcase
                end
`ifdef PS2_WASD_EN
                else begin
                    case (code_q)
                        8'h1D:   btn_d[3] = ~brk_q;
                        8'h1B:   btn_d[2] = ~brk_q;
                        8'h1C:   btn_d[1] = ~brk_q;
                        8'h23:   btn_d[0] = ~brk_q;
                        default: ;
                    endcase
                end
`endif
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q   <= 2'b11;
            dat_sync_q   <= 2'b11;
            filt_q       <= 1'b1;
            fcnt_q       <= '0;
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            code_q       <= 8'h00;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            btn_q        <= '0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            dat_sync_q   <= dat_sync_d;
            filt_q       <= filt_d;
            fcnt_q       <= fcnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            btn_q        <= btn_d;
        end
    end

    assign r_bar_buttons = btn_q;
    assign code          = code_q;
    assign code_valid    = code_valid_q;
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: it drives PS/2 frames bit by bit and compares the DUT against a scan-code-level model.
// The bench compiles with or without PS2_WASD_EN, and the expectations follow the macro.
module tb_ps2_key_decoder;

    localparam int FLEN = 8;
    localparam int TMO  = 200;
    localparam int HALF = 12;
    localparam int GAP  = 30;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] r_bar_buttons;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    int cv_cnt = 0, fe_cnt = 0, cv_long = 0, fe_long = 0, overlap = 0;
    bit cv_prev = 0, fe_prev = 0;
    logic [3:0] bt_at_cv = '0, bt_after = '0;

    logic [3:0] m_btn = '0;
    bit         m_ext = 0, m_brk = 0;
    logic [7:0] m_code = '0;
    int         exp_cv = 0, exp_fe = 0;

    ps2_key_decoder #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .r_bar_buttons (r_bar_buttons),
        .code          (code),
        .code_valid    (code_valid),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cv_prev) bt_after = r_bar_buttons;
        if (code_valid) begin
            cv_cnt++;
            bt_at_cv = r_bar_buttons;
            if (cv_prev) cv_long++;
        end
        if (frame_err) begin
            fe_cnt++;
            if (fe_prev) fe_long++;
        end
        if (code_valid && frame_err) overlap++;
        cv_prev = code_valid;
        fe_prev = frame_err;
    end

    // Model: the bit index in {Up,Down,Left,Right} that a byte controls, or -1 if it controls none.
    function automatic int key_bit(input logic [7:0] b, input bit ext);
        if (ext) begin
            case (b)
                8'h75: return 3;
                8'h72: return 2;
                8'h6B: return 1;
                8'h74: return 0;
                default: ;
            endcase
        end
`ifdef PS2_WASD_EN
        else begin
            case (b)
                8'h1D: return 3;
                8'h1B: return 2;
                8'h1C: return 1;
                8'h23: return 0;
                default: ;
            endcase
        end
`endif
        return -1;
    endfunction

    task automatic model_rx(input logic [7:0] b);
        int k;
        m_code = b;
        exp_cv++;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            k = key_bit(b, m_ext);
            if (k >= 0) m_btn[k] = ~m_brk;
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic model_err();
        exp_fe++;
        m_ext = 0;
        m_brk = 0;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_clks(HALF);
            ps2_clk = 1'b0;
            wait_clks(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_clks(GAP);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        send_bits({~bad_stop, par, b, 1'b0}, 11);
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 0, 0);
        model_rx(b);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wait_clks(5);
        checks++; if (r_bar_buttons !== 4'b0000) begin errors++; $display("FAIL reset_buttons got %b want 0000", r_bar_buttons); end
        checks++; if (code !== 8'h00) begin errors++; $display("FAIL reset_code got %h want 00", code); end
        checks++; if (code_valid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL reset_pulses got cv=%b fe=%b want 0 0", code_valid, frame_err); end
        reset_n = 1'b1;
        wait_clks(50);
        checks++; if (cv_cnt !== 0 || fe_cnt !== 0) begin errors++; $display("FAIL reset_idle got cv=%0d fe=%0d want 0 0", cv_cnt, fe_cnt); end
    endtask

    task automatic test_arrow_make();
        good(8'hE0);
        good(8'h75);
        checks++; if (cv_cnt !== 2) begin errors++; $display("FAIL make_cv_count got %0d want 2", cv_cnt); end
        checks++; if (code !== 8'h75) begin errors++; $display("FAIL make_code got %h want 75", code); end
        checks++; if (r_bar_buttons !== 4'b1000) begin errors++; $display("FAIL make_buttons got %b want 1000", r_bar_buttons); end
        checks++; if (bt_at_cv !== 4'b0000 || bt_after !== 4'b1000) begin errors++; $display("FAIL make_timing got at=%b after=%b want 0000 1000", bt_at_cv, bt_after); end
    endtask

    task automatic test_break_and_multi();
        good(8'hE0); good(8'hF0); good(8'h75);
        checks++; if (r_bar_buttons !== 4'b0000) begin errors++; $display("FAIL break_buttons got %b want 0000", r_bar_buttons); end
        good(8'hE0); good(8'h6B); good(8'hE0); good(8'h74);
        checks++; if (r_bar_buttons !== 4'b0011) begin errors++; $display("FAIL multi_buttons got %b want 0011", r_bar_buttons); end
        checks++; if (cv_cnt !== exp_cv) begin errors++; $display("FAIL multi_cv_count got %0d want %0d", cv_cnt, exp_cv); end
    endtask

    task automatic test_frame_errors();
        good(8'hE0);
        send_frame(8'h72, 1, 0); model_err();
        checks++; if (fe_cnt !== exp_fe || cv_cnt !== exp_cv) begin errors++; $display("FAIL parity_counts got fe=%0d cv=%0d want %0d %0d", fe_cnt, cv_cnt, exp_fe, exp_cv); end
        checks++; if (code !== 8'hE0 || r_bar_buttons !== 4'b0011) begin errors++; $display("FAIL parity_hold got code=%h btn=%b want e0 0011", code, r_bar_buttons); end
        good(8'h75);
        checks++; if (r_bar_buttons !== 4'b0011) begin errors++; $display("FAIL parity_ext_cleared got %b want 0011", r_bar_buttons); end
        send_frame(8'h6B, 0, 1); model_err();
        checks++; if (fe_cnt !== exp_fe || code !== 8'h75) begin errors++; $display("FAIL stop_err got fe=%0d code=%h want %0d 75", fe_cnt, code, exp_fe); end
    endtask

    task automatic test_timeout();
        good(8'hE0);
        send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 5);
        wait_clks(TMO + 40);
        model_err();
        checks++; if (fe_cnt !== exp_fe || cv_cnt !== exp_cv) begin errors++; $display("FAIL timeout_counts got fe=%0d cv=%0d want %0d %0d", fe_cnt, cv_cnt, exp_fe, exp_cv); end
        good(8'h1C);
        checks++; if (code !== 8'h1C || cv_cnt !== exp_cv) begin errors++; $display("FAIL timeout_recover got code=%h cv=%0d want 1c %0d", code, cv_cnt, exp_cv); end
        checks++; if (r_bar_buttons !== m_btn) begin errors++; $display("FAIL timeout_buttons got %b want %b", r_bar_buttons, m_btn); end
    endtask

    task automatic test_glitch();
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        wait_clks(3);
        ps2_clk = 1'b1;
        wait_clks(20);
        ps2_data = 1'b1;
        wait_clks(5);
        good(8'h75);
        checks++; if (code !== 8'h75 || cv_cnt !== exp_cv || fe_cnt !== exp_fe) begin errors++; $display("FAIL glitch got code=%h cv=%0d fe=%0d want 75 %0d %0d", code, cv_cnt, fe_cnt, exp_cv, exp_fe); end
    endtask

    task automatic test_wasd();
        logic [3:0] want;
        good(8'hE0); good(8'hF0); good(8'h6B);
        good(8'hE0); good(8'hF0); good(8'h74);
        checks++; if (r_bar_buttons !== 4'b0000) begin errors++; $display("FAIL wasd_clear got %b want 0000", r_bar_buttons); end
        good(8'h1D);
`ifdef PS2_WASD_EN
        want = 4'b1000;
`else
        want = 4'b0000;
`endif
        checks++; if (r_bar_buttons !== want) begin errors++; $display("FAIL wasd_make got %b want %b", r_bar_buttons, want); end
        good(8'hF0); good(8'h1D);
        checks++; if (r_bar_buttons !== 4'b0000) begin errors++; $display("FAIL wasd_break got %b want 0000", r_bar_buttons); end
    endtask

    task automatic test_random();
        logic [7:0] arrows [4];
        logic [7:0] wasd [4];
        logic [7:0] k;
        bit bp;
        arrows = '{8'h75, 8'h72, 8'h6B, 8'h74};
        wasd   = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 5))
                0: begin k = arrows[$urandom_range(0, 3)]; good(8'hE0); good(k); end
                1: begin k = arrows[$urandom_range(0, 3)]; good(8'hE0); good(8'hF0); good(k); end
                2: begin k = wasd[$urandom_range(0, 3)]; good(k); end
                3: begin k = wasd[$urandom_range(0, 3)]; good(8'hF0); good(k); end
                4: begin k = 8'($urandom_range(0, 255)); good(k); end
                default: begin
                    k = 8'($urandom_range(0, 255));
                    bp = 1'($urandom_range(0, 1));
                    send_frame(k, bp, ~bp);
                    model_err();
                end
            endcase
            checks++; if (r_bar_buttons !== m_btn || code !== m_code) begin errors++; $display("FAIL random_%0d got btn=%b code=%h want %b %h", i, r_bar_buttons, code, m_btn, m_code); end
            checks++; if (cv_cnt !== exp_cv || fe_cnt !== exp_fe) begin errors++; $display("FAIL random_cnt_%0d got cv=%0d fe=%0d want %0d %0d", i, cv_cnt, fe_cnt, exp_cv, exp_fe); end
        end
    endtask

    task automatic test_reset_midframe();
        good(8'hE0); good(8'h75);
        send_bits({1'b1, 1'b0, 8'h6B, 1'b0}, 6);
        reset_n = 1'b0;
        wait_clks(3);
        m_btn = '0; m_ext = 0; m_brk = 0; m_code = '0;
        checks++; if (r_bar_buttons !== 4'b0000 || code !== 8'h00) begin errors++; $display("FAIL midreset got btn=%b code=%h want 0000 00", r_bar_buttons, code); end
        reset_n = 1'b1;
        wait_clks(TMO + 40);
        checks++; if (cv_cnt !== exp_cv || fe_cnt !== exp_fe) begin errors++; $display("FAIL midreset_quiet got cv=%0d fe=%0d want %0d %0d", cv_cnt, fe_cnt, exp_cv, exp_fe); end
        good(8'hE0); good(8'h74);
        checks++; if (r_bar_buttons !== 4'b0001 || code !== 8'h74) begin errors++; $display("FAIL midreset_resume got btn=%b code=%h want 0001 74", r_bar_buttons, code); end
    endtask

    task automatic test_pulse_rules();
        checks++; if (overlap !== 0) begin errors++; $display("FAIL pulse_overlap got %0d want 0", overlap); end
        checks++; if (cv_long !== 0 || fe_long !== 0) begin errors++; $display("FAIL pulse_width got cv=%0d fe=%0d want 0 0", cv_long, fe_long); end
    endtask

    initial begin
        test_reset();
        test_arrow_make();
        test_break_and_multi();
        test_frame_errors();
        test_timeout();
        test_glitch();
        test_wasd();
        test_random();
        test_reset_midframe();
        test_pulse_rules();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
